// File: rtl/fifo_btn_ctrl.sv
// fifo_btn_ctrl: turns a bouncing push-button and a read/write switch into
// single-cycle write/read strobes for an 8x16 FIFO.
//
// Ports:
//   i_Clk, i_Reset         clock, asynchronous active-high reset
//   i_Btn_Raw              raw "next" button (asynchronous, bouncing)
//   i_Switch_Rd_Wr         raw mode switch, 1 = write, 0 = read
//   i_FIFO_Full/Empty      FIFO status flags, sampled in the issue cycle
//   i_Err_Clr              synchronous clear of the sticky error flags
//   o_Wr_En, o_Rd_En       single-cycle strobes to the FIFO
//   o_Count                tracked occupancy, saturating at 0 and DEPTH
//   o_Overflow_Err         sticky: write attempted while full
//   o_Underflow_Err        sticky: read attempted while empty
//   o_Busy                 high from press acceptance until debounced release
//
// Optional feature: define FIFO_BTN_CTRL_HOLD_REPEAT_EN to auto-repeat the
// latched operation every REPEAT_CYCLES cycles while the button stays held.
module fifo_btn_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned COUNT_W         = 5,
   parameter int unsigned REPEAT_CYCLES   = 5000000
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic               i_Btn_Raw,
   input  logic               i_Switch_Rd_Wr,
   input  logic               i_FIFO_Full,
   input  logic               i_FIFO_Empty,
   input  logic               i_Err_Clr,
   output logic               o_Wr_En,
   output logic               o_Rd_En,
   output logic [COUNT_W-1:0] o_Count,
   output logic               o_Overflow_Err,
   output logic               o_Underflow_Err,
   output logic               o_Busy
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

   logic               btn_meta_q, btn_sync_q;
   logic               sw_meta_q, sw_sync_q;
   logic [DbW-1:0]     db_cnt_q;
   logic               btn_db_q;
   state_e             state_q;
   logic               mode_q;
   logic               busy_q;
   logic               ovf_q, udf_q;
   logic [COUNT_W-1:0] count_q;
   logic               wr_go, rd_go;

`ifdef FIFO_BTN_CTRL_HOLD_REPEAT_EN
   localparam int unsigned RptW = $clog2(REPEAT_CYCLES);
   logic [RptW-1:0] rpt_cnt_q;
`else
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_CYCLES;
`endif

   // Two-flop synchronizers for the asynchronous board inputs.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         sw_meta_q  <= 1'b0;
         sw_sync_q  <= 1'b0;
      end else begin
         btn_meta_q <= i_Btn_Raw;
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= i_Switch_Rd_Wr;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // Debounce: the level only follows the synced button after it has
   // disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         db_cnt_q <= '0;
         btn_db_q <= 1'b0;
      end else if (btn_sync_q == btn_db_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
         btn_db_q <= ~btn_db_q;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + 1'b1;
      end
   end

   // Strobes decode the issue state directly so full/empty are judged in the
   // issue cycle itself rather than one cycle early.
   assign wr_go = (state_q == StIssue) &&  mode_q && !i_FIFO_Full;
   assign rd_go = (state_q == StIssue) && !mode_q && !i_FIFO_Empty;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= StIdle;
         mode_q    <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         count_q   <= '0;
`ifdef FIFO_BTN_CTRL_HOLD_REPEAT_EN
         rpt_cnt_q <= '0;
`endif
      end else begin
         // Clear first so a same-cycle set below takes priority.
         if (i_Err_Clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end
         if (state_q == StIssue) begin
            if (mode_q && i_FIFO_Full) ovf_q <= 1'b1;
            if (!mode_q && i_FIFO_Empty) udf_q <= 1'b1;
         end

         if (wr_go && (count_q != COUNT_W'(DEPTH))) begin
            count_q <= count_q + 1'b1;
         end else if (rd_go && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               // Level can only be high here on a fresh rising edge.
               if (btn_db_q) begin
                  state_q <= StIssue;
                  mode_q  <= sw_sync_q;
                  busy_q  <= 1'b1;
               end
            end
            StIssue: begin
               state_q <= StHold;
`ifdef FIFO_BTN_CTRL_HOLD_REPEAT_EN
               rpt_cnt_q <= '0;
`endif
            end
            StHold: begin
               if (!btn_db_q) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
`ifdef FIFO_BTN_CTRL_HOLD_REPEAT_EN
                  rpt_cnt_q <= '0;
               end else if (rpt_cnt_q == RptW'(REPEAT_CYCLES - 2)) begin
                  // Issue cycle plus REPEAT_CYCLES-1 hold cycles per period.
                  state_q   <= StIssue;
                  rpt_cnt_q <= '0;
               end else begin
                  rpt_cnt_q <= rpt_cnt_q + 1'b1;
`endif
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_Wr_En         = wr_go;
   assign o_Rd_En         = rd_go;
   assign o_Count         = count_q;
   assign o_Overflow_Err  = ovf_q;
   assign o_Underflow_Err = udf_q;
   assign o_Busy          = busy_q;

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
module tb_fifo_btn_ctrl;

   localparam int unsigned D     = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;
   localparam int unsigned RPT   = 8;
   // Press-to-strobe latency: 2 sync flops, D debounce cycles, 1 FSM cycle.
   localparam int LAT = 2 + D + 1;

   logic          clk = 1'b0;
   logic          rst, btn, sw, full, empty, clr;
   logic          wr, rd, ovf, udf, busy;
   logic [CW-1:0] cnt;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   seen_wr = 0;
   int   seen_rd = 0;
   int   seen_both = 0;
   int   first_cyc = -1;

   // Reference model state.
   int   m_count = 0;
   logic m_ovf = 1'b0;
   logic m_udf = 1'b0;

   always #5 clk = ~clk;

   fifo_btn_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .DEPTH(DEPTH),
      .COUNT_W(CW),
      .REPEAT_CYCLES(RPT)
   ) dut (
      .i_Clk(clk),
      .i_Reset(rst),
      .i_Btn_Raw(btn),
      .i_Switch_Rd_Wr(sw),
      .i_FIFO_Full(full),
      .i_FIFO_Empty(empty),
      .i_Err_Clr(clr),
      .o_Wr_En(wr),
      .o_Rd_En(rd),
      .o_Count(cnt),
      .o_Overflow_Err(ovf),
      .o_Underflow_Err(udf),
      .o_Busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (wr === 1'b1) seen_wr++;
      if (rd === 1'b1) seen_rd++;
      if (wr === 1'b1 && rd === 1'b1) seen_both++;
      if (first_cyc < 0 && (wr === 1'b1 || rd === 1'b1)) first_cyc = cyc;
   endtask

   // Operations issued by one press held for 'hold' cycles. The debounced
   // level falls D+2 cycles after release; a repeat lands every RPT cycles
   // after the first issue while the level is still high.
   function automatic int ops_for(input int hold);
`ifdef FIFO_BTN_CTRL_HOLD_REPEAT_EN
      return 1 + (hold + int'(D) + 2 - LAT) / int'(RPT);
`else
      return 1 + 0 * hold;
`endif
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(cnt), m_count);
      check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
      check({tag, "_udf"}, 32'(udf), 32'(m_udf));
   endtask

   // Button rises now (or reset just released with it held) and is held.
   task automatic press_body(input string tag, input bit mode, input int hold, input bit f,
                             input bit e, input bit clr_issue, input bit sw_flip);
      int c0, wr0, rd0, both0, ops, allowed, e_last, idle_at;
      wr0 = seen_wr; rd0 = seen_rd; both0 = seen_both; first_cyc = -1;
      btn = 1'b1;
      c0 = cyc;
      for (int t = 1; t <= hold; t++) begin
         step();
         clr = 1'b0;
         if (t == LAT) begin
            check({tag, "_busy_issue"}, 32'(busy), 1);
            if (clr_issue) clr = 1'b1;
            if (sw_flip) sw = ~mode;
         end
      end
      clr = 1'b0;
      btn = 1'b0;
      ops = ops_for(hold);
      e_last = LAT + (ops - 1) * int'(RPT);
      idle_at = (e_last + 2 - hold > int'(D) + 3) ? e_last + 2 - hold : int'(D) + 3;
      for (int u = 1; u <= int'(D) + 8; u++) begin
         step();
         if (u == idle_at - 1) check({tag, "_busy_held"}, 32'(busy), 1);
         if (u == idle_at) check({tag, "_busy_release"}, 32'(busy), 0);
      end
      if (clr_issue) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      allowed = 0;
      for (int k = 0; k < ops; k++) begin
         if (mode) begin
            if (f) m_ovf = 1'b1;
            else begin
               allowed++;
               if (m_count < int'(DEPTH)) m_count++;
            end
         end else begin
            if (e) m_udf = 1'b1;
            else begin
               allowed++;
               if (m_count > 0) m_count--;
            end
         end
      end
      check({tag, "_wr_pulses"}, seen_wr - wr0, mode ? allowed : 0);
      check({tag, "_rd_pulses"}, seen_rd - rd0, mode ? 0 : allowed);
      check({tag, "_no_overlap"}, seen_both - both0, 0);
      if (allowed > 0) check({tag, "_latency"}, first_cyc - c0, LAT);
      check_state(tag);
   endtask

   task automatic press(input string tag, input bit mode, input int hold, input bit f,
                        input bit e, input bit bounce, input bit clr_issue, input bit sw_flip);
      int wr0, rd0, nb;
      sw = mode; full = f; empty = e;
      repeat (3) step();
      if (bounce) begin
         wr0 = seen_wr; rd0 = seen_rd;
         nb = 3 + int'($urandom_range(0, 3));
         for (int i = 0; i < nb; i++) begin
            btn = 1'b1;
            repeat ($urandom_range(1, D - 1)) step();
            btn = 1'b0;
            repeat ($urandom_range(1, D - 1)) step();
         end
         repeat (D) step();
         check({tag, "_bounce_quiet"}, (seen_wr - wr0) + (seen_rd - rd0), 0);
      end
      press_body(tag, mode, hold, f, e, clr_issue, sw_flip);
   endtask

   task automatic clear_errs(input string tag);
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check({tag, "_ovf_clr"}, 32'(ovf), 0);
      check({tag, "_udf_clr"}, 32'(udf), 0);
   endtask

   initial begin
      bit r_mode, r_f, r_e, r_b, r_c, r_s;
      int r_hold;
      rst = 1'b1; btn = 1'b0; sw = 1'b0; full = 1'b0; empty = 1'b0; clr = 1'b0;
      step();
      step();
      check("rst_wr", 32'(wr), 0);
      check("rst_rd", 32'(rd), 0);
      check("rst_busy", 32'(busy), 0);
      check_state("rst");
      rst = 1'b0;
      step();

      // Two writes (one clean, one bounced), then two reads: count 1,2,1,0.
      press("wr_a", 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press("wr_bounce", 1'b1, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      press("rd_a", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press("rd_b", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Blocked operations and sticky flags.
      press("rd_empty", 1'b0, 12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      clear_errs("clr1");
      press("wr_full", 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      press("wr_full_setwins", 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      clear_errs("clr2");

      // Switch flipped during hold keeps the write; next press reads.
      press("wr_flip", 1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      press("rd_after_flip", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a hold with count at 3.
      press("wr_pre1", 1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      press("wr_pre2", 1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      btn = 1'b1;
      repeat (LAT + 3) step();
      if (m_count < int'(DEPTH)) m_count++;
      check("mid_hold_count", 32'(cnt), m_count);
      check("mid_hold_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_wr", 32'(wr), 0);
      check("async_rst_rd", 32'(rd), 0);
      check("async_rst_busy", 32'(busy), 0);
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
      check_state("async_rst");
      step();
      step();
      rst = 1'b0;
      press_body("held_thru_rst", 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Saturation at DEPTH and at 0.
      for (int i = 0; i < int'(DEPTH) + 1; i++)
         press($sformatf("sat_wr%0d", i), 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < int'(DEPTH) + 1; i++)
         press($sformatf("sat_rd%0d", i), 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized presses against the model.
      for (int n = 0; n < 30; n++) begin
         r_mode = 1'($urandom_range(0, 1));
         r_f    = ($urandom_range(0, 3) == 0);
         r_e    = ($urandom_range(0, 3) == 0);
         r_b    = 1'($urandom_range(0, 1));
         r_c    = ($urandom_range(0, 7) == 0);
         r_s    = 1'($urandom_range(0, 1));
         r_hold = int'($urandom_range(D + 4, D + 20));
         press($sformatf("rnd%0d", n), r_mode, r_hold, r_f, r_e, r_b, r_c, r_s);
         if ($urandom_range(0, 4) == 0) clear_errs($sformatf("rnd_clr%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
